// File: rtl/argmax_pkg.sv
// Shared types and helpers for the argmax classification stage.
package argmax_pkg;

  typedef enum logic {ACCUM, DONE} argmax_state_t;

  function automatic int idx_width(input int m);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational running-max update for one accepted element.
// The second-best path exists only when ARGMAX_MARGIN_EN is defined.
module argmax_cmp #(
  parameter int T  = 16,
  parameter int IW = 3
) (
  input  logic signed [T-1:0] best_val,
  input  logic        [IW-1:0] best_idx,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [T-1:0] second_val,
  output logic signed [T-1:0] nxt_second_val,
`endif
  input  logic signed [T-1:0] input_data,
  input  logic        [IW-1:0] cnt,
  input  logic                first,
  output logic signed [T-1:0] nxt_best_val,
  output logic        [IW-1:0] nxt_best_idx
);

  // Strict greater-than keeps the earliest index on ties.
  always_comb begin
    nxt_best_val = best_val;
    nxt_best_idx = best_idx;
`ifdef ARGMAX_MARGIN_EN
    nxt_second_val = second_val;
`endif
    if (first) begin
      nxt_best_val = input_data;
      nxt_best_idx = '0;
`ifdef ARGMAX_MARGIN_EN
      nxt_second_val = {1'b1, {(T-1){1'b0}}};
`endif
    end else if (input_data > best_val) begin
      nxt_best_val = input_data;
      nxt_best_idx = cnt;
`ifdef ARGMAX_MARGIN_EN
      nxt_second_val = best_val;
`endif
    end
`ifdef ARGMAX_MARGIN_EN
    else if (input_data > second_val) begin
      nxt_second_val = input_data;
    end
`endif
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over M signed T-bit elements; one result beat per vector.
// Optional ARGMAX_MARGIN_EN adds output_margin = best minus second-best.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter  int M  = 8,
  parameter  int T  = 16,
  localparam int IW = idx_width(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic        [IW-1:0] output_index,
`ifdef ARGMAX_MARGIN_EN
  output logic        [T:0]   output_margin,
`endif
  output logic signed [T-1:0] output_max
);

  argmax_state_t       state;
  logic [IW-1:0]       cnt;
  logic signed [T-1:0] best_val;
  logic [IW-1:0]       best_idx;
  logic signed [T-1:0] nxt_best_val;
  logic [IW-1:0]       nxt_best_idx;
  logic                first;
  logic                accept;
  logic                last;

`ifdef ARGMAX_MARGIN_EN
  logic signed [T-1:0] second_val;
  logic signed [T-1:0] nxt_second_val;

  // Sign-extend both operands; best >= second always, so the difference fits unsigned.
  function automatic logic [T:0] margin_of(input logic signed [T-1:0] b,
                                           input logic signed [T-1:0] s);
    return {b[T-1], b} - {s[T-1], s};
  endfunction
`endif

  assign first  = (cnt == '0);
  assign last   = (cnt == IW'(M - 1));
  assign accept = input_valid && input_ready;

  argmax_cmp #(.T(T), .IW(IW)) u_cmp (
    .best_val       (best_val),
    .best_idx       (best_idx),
`ifdef ARGMAX_MARGIN_EN
    .second_val     (second_val),
    .nxt_second_val (nxt_second_val),
`endif
    .input_data     (input_data),
    .cnt            (cnt),
    .first          (first),
    .nxt_best_val   (nxt_best_val),
    .nxt_best_idx   (nxt_best_idx)
  );

  // Handshake flags are registered state decodes, never combinational from the peer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ACCUM;
      cnt          <= '0;
      best_val     <= '0;
      best_idx     <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_val   <= '0;
`endif
      input_ready  <= 1'b1;
      output_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            best_val <= nxt_best_val;
            best_idx <= nxt_best_idx;
`ifdef ARGMAX_MARGIN_EN
            second_val <= nxt_second_val;
`endif
            if (last) begin
              cnt          <= '0;
              state        <= DONE;
              input_ready  <= 1'b0;
              output_valid <= 1'b1;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end
        DONE: begin
          if (output_ready) begin
            state        <= ACCUM;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ACCUM;
          input_ready  <= 1'b1;
          output_valid <= 1'b0;
        end
      endcase
    end
  end

  assign output_index = best_idx;
  assign output_max   = best_val;
`ifdef ARGMAX_MARGIN_EN
  assign output_margin = margin_of(best_val, second_val);
`endif

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream (M=8, T=16); margin checks when ARGMAX_MARGIN_EN is set.
module tb_argmax_stream;

  logic               clk;
  logic               reset;
  logic               input_valid;
  logic               input_ready;
  logic signed [15:0] input_data;
  logic               output_valid;
  logic               output_ready;
  logic        [2:0]  output_index;
  logic signed [15:0] output_max;
`ifdef ARGMAX_MARGIN_EN
  logic        [16:0] output_margin;
`endif

  int checks;
  int failures;
  int vec[8];

  argmax_stream #(.M(8), .T(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .input_valid   (input_valid),
    .input_ready   (input_ready),
    .input_data    (input_data),
    .output_valid  (output_valid),
    .output_ready  (output_ready),
    .output_index  (output_index),
`ifdef ARGMAX_MARGIN_EN
    .output_margin (output_margin),
`endif
    .output_max    (output_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives vec[0..n-1] one per cycle; returns 1 time unit after the last edge.
  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      input_valid = 1'b1;
      input_data  = 16'(vec[k]);
      @(posedge clk); #1;
    end
    input_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; input_valid = 1'b0; input_data = '0; output_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL rst_ovalid got=%b exp=0", output_valid); end
    checks++; if (input_ready !== 1'b1) begin failures++; $display("FAIL rst_iready got=%b exp=1", input_ready); end
    checks++; if (output_index !== 3'd0) begin failures++; $display("FAIL rst_index got=%0d exp=0", output_index); end
    checks++; if (output_max !== 16'sd0) begin failures++; $display("FAIL rst_max got=%0d exp=0", output_max); end
`ifdef ARGMAX_MARGIN_EN
    checks++; if (output_margin !== 17'd0) begin failures++; $display("FAIL rst_margin got=%0d exp=0", output_margin); end
`endif
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_tie;
    vec = '{5, -3, 12, 7, 12, 0, -20, 1};
    output_ready = 1'b1;
    send(7);
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL tie_early_valid got=%b exp=0", output_valid); end
    input_valid = 1'b1; input_data = 16'(vec[7]);
    @(posedge clk); #1;
    input_valid = 1'b0;
    checks++; if (output_valid !== 1'b1) begin failures++; $display("FAIL tie_valid got=%b exp=1", output_valid); end
    checks++; if (input_ready !== 1'b0) begin failures++; $display("FAIL tie_iready got=%b exp=0", input_ready); end
    checks++; if (output_index !== 3'd2) begin failures++; $display("FAIL tie_index got=%0d exp=2", output_index); end
    checks++; if (output_max !== 16'sd12) begin failures++; $display("FAIL tie_max got=%0d exp=12", output_max); end
`ifdef ARGMAX_MARGIN_EN
    checks++; if (output_margin !== 17'd0) begin failures++; $display("FAIL tie_margin got=%0d exp=0", output_margin); end
`endif
    @(posedge clk); #1;
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL tie_post_valid got=%b exp=0", output_valid); end
    checks++; if (input_ready !== 1'b1) begin failures++; $display("FAIL tie_post_iready got=%b exp=1", input_ready); end
  endtask

  task automatic test_negative;
    vec = '{-5, -1, -9, -32768, -2, -7, -3, -4};
    send(8);
    checks++; if (output_valid !== 1'b1) begin failures++; $display("FAIL neg_valid got=%b exp=1", output_valid); end
    checks++; if (output_index !== 3'd1) begin failures++; $display("FAIL neg_index got=%0d exp=1", output_index); end
    checks++; if (output_max !== -16'sd1) begin failures++; $display("FAIL neg_max got=%0d exp=-1", output_max); end
`ifdef ARGMAX_MARGIN_EN
    checks++; if (output_margin !== 17'd1) begin failures++; $display("FAIL neg_margin got=%0d exp=1", output_margin); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_extremes;
    vec = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767};
    send(8);
    checks++; if (output_valid !== 1'b1) begin failures++; $display("FAIL ext_valid got=%b exp=1", output_valid); end
    checks++; if (output_index !== 3'd7) begin failures++; $display("FAIL ext_index got=%0d exp=7", output_index); end
    checks++; if (output_max !== 16'sh7FFF) begin failures++; $display("FAIL ext_max got=%0d exp=32767", output_max); end
`ifdef ARGMAX_MARGIN_EN
    checks++; if (output_margin !== 17'd65535) begin failures++; $display("FAIL ext_margin got=%0d exp=65535", output_margin); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    vec = '{3, 9, -4, 9, 1, 2, 8, 0};
    output_ready = 1'b0;
    send(8);
    input_valid = 1'b1; input_data = 16'sd999;
    for (int c = 0; c < 5; c++) begin
      checks++; if (output_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, output_valid); end
      checks++; if (input_ready !== 1'b0) begin failures++; $display("FAIL bp_iready c=%0d got=%b exp=0", c, input_ready); end
      checks++; if (output_index !== 3'd1) begin failures++; $display("FAIL bp_index c=%0d got=%0d exp=1", c, output_index); end
      checks++; if (output_max !== 16'sd9) begin failures++; $display("FAIL bp_max c=%0d got=%0d exp=9", c, output_max); end
`ifdef ARGMAX_MARGIN_EN
      checks++; if (output_margin !== 17'd0) begin failures++; $display("FAIL bp_margin c=%0d got=%0d exp=0", c, output_margin); end
`endif
      @(posedge clk); #1;
    end
    output_ready = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", output_valid); end
    checks++; if (input_ready !== 1'b1) begin failures++; $display("FAIL bp_release_iready got=%b exp=1", input_ready); end
  endtask

  task automatic test_reset_midvector;
    vec = '{100, 200, 300, 0, 0, 0, 0, 0};
    send(3);
    #2 reset = 1'b0;
    #1;
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", output_valid); end
    checks++; if (input_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_iready got=%b exp=1", input_ready); end
    checks++; if (output_max !== 16'sd0) begin failures++; $display("FAIL mid_rst_max got=%0d exp=0", output_max); end
    @(posedge clk); #1;
    reset = 1'b1;
    vec = '{1, 2, 3, 4, 5, 6, 7, 0};
    send(8);
    checks++; if (output_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", output_valid); end
    checks++; if (output_index !== 3'd6) begin failures++; $display("FAIL mid_index got=%0d exp=6", output_index); end
    checks++; if (output_max !== 16'sd7) begin failures++; $display("FAIL mid_max got=%0d exp=7", output_max); end
`ifdef ARGMAX_MARGIN_EN
    checks++; if (output_margin !== 17'd1) begin failures++; $display("FAIL mid_margin got=%0d exp=1", output_margin); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int stream[16];
    int exp_idx[2];
    int exp_max[2];
    int exp_mrg[2];
    int res_cyc[2];
    int i;
    int nres;
    logic rdy;
    stream  = '{1, 2, 3, 4, 5, 6, 7, 8, 50, -1, -2, -3, -4, -5, -6, -7};
    exp_idx = '{7, 0};
    exp_max = '{8, 50};
    exp_mrg = '{1, 51};
    res_cyc = '{0, 0};
    i = 0; nres = 0;
    output_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nres < 2; cyc++) begin
      input_valid = (i < 16);
      input_data  = 16'(stream[(i < 16) ? i : 15]);
      rdy = input_ready;
      @(posedge clk);
      if (rdy && input_valid) i++;
      #1;
      if (output_valid) begin
        checks++; if (output_index !== 3'(exp_idx[nres])) begin failures++; $display("FAIL b2b_index r=%0d got=%0d exp=%0d", nres, output_index, exp_idx[nres]); end
        checks++; if (output_max !== 16'(exp_max[nres])) begin failures++; $display("FAIL b2b_max r=%0d got=%0d exp=%0d", nres, output_max, exp_max[nres]); end
`ifdef ARGMAX_MARGIN_EN
        checks++; if (output_margin !== 17'(exp_mrg[nres])) begin failures++; $display("FAIL b2b_margin r=%0d got=%0d exp=%0d", nres, output_margin, exp_mrg[nres]); end
`endif
        res_cyc[nres] = cyc;
        nres++;
      end
    end
    input_valid = 1'b0;
    checks++; if (nres !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", nres); end
    checks++; if (res_cyc[1] - res_cyc[0] !== 9) begin failures++; $display("FAIL b2b_period got=%0d exp=9", res_cyc[1] - res_cyc[0]); end
    checks++; if (res_cyc[0] !== 7) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=7", res_cyc[0]); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_tie;
    test_negative;
    test_extremes;
    test_backpressure;
    test_reset_midvector;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Downstream consumer of the final fully-connected layer (fc_M_N_T_P_L top).
- Accepts the layer's M signed T-bit outputs, one per handshake, over the same valid/ready stream protocol.
- Returns the class index of the largest value, plus that value, as one result beat per inference.
- Single layer-to-classification stage; no matrix storage, only running-max state.

Parameters:
- M, 8, number of outputs per inference (vector length); must be ≥ 2.
- T, 16, data width of each signed element.
- IW, $clog2(M) (localparam), width of the index output.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- input_valid  input  1  upstream element valid.
- input_ready  output  1  block can accept an element.
- input_data  input  T  signed element from the fc layer.
- output_valid  output  1  result beat valid.
- output_ready  input  1  downstream accepts result.
- output_index  output  IW  index (0..M-1) of the maximum element.
- output_max  output  T  signed maximum value.

Behaviour:
- States: ACCUM (accepting elements) and DONE (result held).
- Input handshake: an element is accepted when input_valid && input_ready on a rising edge.
- Output handshake: the result completes when output_valid && output_ready on a rising edge.
- Reset (asynchronous, any time, including mid-vector):
  - state=ACCUM, cnt=0, best_val=0, best_idx=0.
  - output_valid=0, input_ready=1, output_index=0, output_max=0.
  - Any partial vector is discarded.
- ACCUM:
  - input_ready=1, output_valid=0.
  - Accept at cnt=0: load best_val=input_data, best_idx=0 unconditionally.
  - Accept at cnt=k>0: if signed input_data > best_val (strict), load best_val=input_data, best_idx=k. Ties keep the earlier index.
  - cnt increments on each accept.
  - Accept at cnt=M-1: next state DONE, cnt wraps to 0.
- DONE:
  - input_ready=0, output_valid=1.
  - output_index=best_idx and output_max=best_val, held stable until the output handshake.
  - Output handshake: next state ACCUM, input_ready=1 the following cycle.
  - input_valid during DONE is ignored; the element stays pending upstream.
- Latency:
  - output_valid rises on the cycle after the Mth input accept.
  - Minimum period per inference is M+1 cycles.
- Arithmetic: comparison is signed, full T bits, no saturation or truncation. Extremes (-2^(T-1), 2^(T-1)-1) must compare correctly.
- No combinational path from input_valid to input_ready, or from output_ready to output_valid. Both are registered state decodes.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- With the macro defined:
  - Adds output port output_margin, T+1 bits, unsigned.
  - Value is best_val minus second-largest value. It is 0 on a tie for the maximum.
  - Second-best tracking:
    - cnt=0: second_val = -2^(T-1).
    - New max: second_val takes the old best_val.
    - Otherwise, if input_data > second_val, second_val takes input_data.
  - output_margin is valid and held with output_valid; reset value 0.
- Without the macro: no second-best register and no output_margin port; behaviour otherwise identical.

Decomposition:
- Package argmax_pkg:
  - typedef enum logic {ACCUM, DONE} argmax_state_t.
  - Function idx_width(M) returning $clog2(M).
- Sub-module argmax_cmp:
  - Combinational update: takes best_val, best_idx, (second_val), input_data, cnt, first flag.
  - Produces next best/second values and index.
  - The top level holds the FSM, counter and registers.

Test Plan:
- M=8, T=16, stream [5,-3,12,7,12,0,-20,1] with output_ready=1 → output_index=2, output_max=12 (tie keeps first); output_valid exactly one cycle after the 8th accept. Margin build: output_margin=0.
- All-negative vector [-5,-1,-9,-32768,-2,-7,-3,-4] → index=1, max=-1. Margin build: output_margin=1.
- Extremes [-32768 ×7, 32767 last] → index=7, max=32767. Margin build: output_margin=65535.
- Backpressure: complete a vector with output_ready=0 for 5 cycles → output_valid and outputs stable, input_ready=0, input_valid=1 ignored. Raise output_ready → one handshake, input_ready=1 next cycle.
- Reset low asynchronously after 3 accepts ([100,200,300]) → immediate output_valid=0, input_ready=1. Then vector [1,2,3,4,5,6,7,0] → index=6, max=7 (no stale 300).
- Two back-to-back vectors with input_valid held high and output_ready=1 → two results, period 9 cycles, second result independent of the first.
